trig_pulse_gen: RTL and testbench



---
 rtl/trig_pulse_gen.sv | 133 +++++++++++++
 tb/tb_trig_pulse_gen.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trig_pulse_gen.sv
// Trigger pulse generator: drives a negative-going pulse onto a single trigger
// line. The low time is programmable and never shorter than MIN_LOW. A
// programmable high-time holdoff follows it. Requests that arrive while a
// sequence is in flight are counted in a saturating counter. They are not queued.
//
// Request handshake: trig_i is a strobe with no ready signal. A request is
// accepted if the FSM is IDLE at the sampling edge. Otherwise it is dropped and
// counted as a miss. Only registered values drive the outputs. No combinational
// path exists from trig_i to any output.
module trig_pulse_gen #(
    parameter int CNT_W   = 16,
    parameter int MIN_LOW = 12,
    parameter int MISS_W  = 8
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              trig_i,
    input  logic [CNT_W-1:0]  low_cycles_i,
    input  logic [CNT_W-1:0]  hold_cycles_i,
    input  logic              miss_clr_i,
    output logic              line_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [MISS_W-1:0] miss_cnt_o,
    output logic [1:0]        state_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MIN_LOW_C = CNT_W'(MIN_LOW);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    r_hold;
    logic                r_line;
    logic                r_busy;
    logic                r_done;
    logic [MISS_W-1:0]   r_miss;

    logic [CNT_W-1:0]    w_low_len;
    logic                w_cnt_zero;
    logic                w_hold_zero;
    logic                w_in_seq;
    logic                w_miss_sat;

    // Clamp the requested low time so downstream detectors always qualify it
    assign w_low_len   = (low_cycles_i < MIN_LOW_C) ? MIN_LOW_C : low_cycles_i;
    assign w_cnt_zero  = (r_cnt == '0);
    assign w_hold_zero = (r_hold == '0);
    assign w_in_seq    = (r_state != ST_IDLE);
    assign w_miss_sat  = &r_miss;

    // Sequencer: IDLE -> LOW (N cycles) -> HOLD (H cycles, skipped if 0) -> IDLE
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_hold  <= '0;
            r_line  <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_line <= 1'b1;
                    r_busy <= 1'b0;
                    if (trig_i) begin
                        // Lengths are latched only here, so later input changes
                        // cannot stretch or cut a pulse in flight
                        r_cnt   <= w_low_len - ONE_C;
                        r_hold  <= hold_cycles_i;
                        r_state <= ST_LOW;
                        r_line  <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_LOW: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - ONE_C;
                    end else if (!w_hold_zero) begin
                        r_cnt   <= r_hold - ONE_C;
                        r_state <= ST_HOLD;
                        r_line  <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_line  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - ONE_C;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_line  <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Saturating count of requests dropped while busy; a clear beats a miss
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_miss <= '0;
        end else if (miss_clr_i) begin
            r_miss <= '0;
        end else if (trig_i && w_in_seq && !w_miss_sat) begin
            r_miss <= r_miss + MISS_W'(1);
        end
    end

    assign line_o     = r_line;
    assign busy_o     = r_busy;
    assign done_o     = r_done;
    assign miss_cnt_o = r_miss;
    assign state_o    = r_state;

endmodule

// File: tb/tb_trig_pulse_gen.sv
// Directed bench for trig_pulse_gen. Inputs change on the falling edge and
// outputs are sampled there too. Sample index 1 is the first falling edge after
// the rising edge that accepted a request.
module tb_trig_pulse_gen;

    localparam int CNT_W = 16;

    logic             clk_i = 1'b0;
    logic             rstn_i;
    logic             trig_i;
    logic [CNT_W-1:0] low_cycles_i;
    logic [CNT_W-1:0] hold_cycles_i;
    logic             miss_clr_i;

    logic             line_o, busy_o, done_o;
    logic [7:0]       miss_cnt_o;
    logic [1:0]       state_o;
    logic             line_s, busy_s, done_s;
    logic [1:0]       miss_cnt_s;
    logic [1:0]       state_s;

    int checks   = 0;
    int failures = 0;

    trig_pulse_gen #(.CNT_W(CNT_W), .MIN_LOW(12), .MISS_W(8)) u_dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .trig_i(trig_i),
        .low_cycles_i(low_cycles_i), .hold_cycles_i(hold_cycles_i),
        .miss_clr_i(miss_clr_i), .line_o(line_o), .busy_o(busy_o),
        .done_o(done_o), .miss_cnt_o(miss_cnt_o), .state_o(state_o)
    );

    // Narrow-counter instance sharing the same stimulus, for saturation
    trig_pulse_gen #(.CNT_W(CNT_W), .MIN_LOW(12), .MISS_W(2)) u_dut_sat (
        .clk_i(clk_i), .rstn_i(rstn_i), .trig_i(trig_i),
        .low_cycles_i(low_cycles_i), .hold_cycles_i(hold_cycles_i),
        .miss_clr_i(miss_clr_i), .line_o(line_s), .busy_o(busy_s),
        .done_o(done_s), .miss_cnt_o(miss_cnt_s), .state_o(state_s)
    );

    // Clock
    always #5 clk_i = ~clk_i;

    // Driver: one-cycle request, returns at the sample after the accepting edge
    task automatic drive_trig();
        trig_i = 1'b1;
        @(negedge clk_i);
        trig_i = 1'b0;
    endtask

    // Driver: one-cycle clear of the miss counters
    task automatic drive_clear();
        miss_clr_i = 1'b1;
        @(negedge clk_i);
        miss_clr_i = 1'b0;
    endtask

    // Observation over a fixed window (no comparisons inside)
    task automatic measure(input int win, output int first_low, output int low_len,
                           output int busy_len, output int done_at, output int done_cnt);
        first_low = -1; low_len = 0; busy_len = 0; done_at = -1; done_cnt = 0;
        for (int i = 1; i <= win; i++) begin
            if (line_o === 1'b0) begin
                low_len++;
                if (first_low < 0) first_low = i;
            end
            if (busy_o === 1'b1) busy_len++;
            if (done_o === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
            end
            @(negedge clk_i);
        end
    endtask

    task automatic test_reset();
        rstn_i = 1'b0; trig_i = 1'b0; miss_clr_i = 1'b0;
        low_cycles_i = 16'd20; hold_cycles_i = 16'd5;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            trig_i = ~trig_i;
            checks++;
            if (line_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0 || miss_cnt_o !== 8'd0
                || state_o !== 2'd0) begin
                failures++;
                $display("FAIL reset_hold got line=%b busy=%b done=%b miss=%0d st=%0d exp 1 0 0 0 0",
                         line_o, busy_o, done_o, miss_cnt_o, state_o);
            end
        end
        trig_i = 1'b0;
        @(negedge clk_i);
        rstn_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            checks++;
            if (line_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0 || miss_cnt_o !== 8'd0) begin
                failures++;
                $display("FAIL idle_after_reset got line=%b busy=%b done=%b miss=%0d exp 1 0 0 0",
                         line_o, busy_o, done_o, miss_cnt_o);
            end
        end
    endtask

    task automatic test_basic();
        int fl, ll, bl, da, dc;
        low_cycles_i = 16'd20; hold_cycles_i = 16'd5;
        drive_trig();
        // Changing the lengths mid-sequence must not affect this pulse
        low_cycles_i = 16'd50; hold_cycles_i = 16'd9;
        measure(60, fl, ll, bl, da, dc);
        checks++;
        if (fl !== 1) begin failures++; $display("FAIL basic_first_low got=%0d exp=1", fl); end
        checks++;
        if (ll !== 20) begin failures++; $display("FAIL basic_low_len got=%0d exp=20", ll); end
        checks++;
        if (bl !== 25) begin failures++; $display("FAIL basic_busy_len got=%0d exp=25", bl); end
        checks++;
        if (da !== 26) begin failures++; $display("FAIL basic_done_at got=%0d exp=26", da); end
        checks++;
        if (dc !== 1) begin failures++; $display("FAIL basic_done_cnt got=%0d exp=1", dc); end
        checks++;
        if (miss_cnt_o !== 8'd0) begin
            failures++; $display("FAIL basic_miss got=%0d exp=0", miss_cnt_o);
        end
    endtask

    task automatic test_clamp();
        int fl, ll, bl, da, dc;
        logic [CNT_W-1:0] lows [2];
        lows[0] = 16'd3; lows[1] = 16'd0;
        for (int t = 0; t < 2; t++) begin
            low_cycles_i = lows[t]; hold_cycles_i = 16'd0;
            drive_trig();
            measure(30, fl, ll, bl, da, dc);
            checks++;
            if (ll !== 12) begin failures++; $display("FAIL clamp_low_len req=%0d got=%0d exp=12", lows[t], ll); end
            checks++;
            if (bl !== 12) begin failures++; $display("FAIL clamp_busy_len req=%0d got=%0d exp=12", lows[t], bl); end
            checks++;
            if (da !== 13 || dc !== 1) begin
                failures++; $display("FAIL clamp_done req=%0d got at=%0d n=%0d exp at=13 n=1", lows[t], da, dc);
            end
        end
    endtask

    task automatic test_missed();
        int ll, da, dc;
        ll = 0; da = -1; dc = 0;
        drive_clear();
        low_cycles_i = 16'd12; hold_cycles_i = 16'd4;
        drive_trig();
        // Requests sampled in LOW (idx 3, 10) and in the last HOLD cycle (idx 16)
        for (int i = 1; i <= 30; i++) begin
            if (line_o === 1'b0) ll++;
            if (done_o === 1'b1) begin dc++; if (da < 0) da = i; end
            trig_i = (i == 3 || i == 10 || i == 16);
            @(negedge clk_i);
        end
        trig_i = 1'b0;
        checks++;
        if (ll !== 12) begin failures++; $display("FAIL missed_low_len got=%0d exp=12", ll); end
        checks++;
        if (da !== 17 || dc !== 1) begin
            failures++; $display("FAIL missed_done got at=%0d n=%0d exp at=17 n=1", da, dc);
        end
        checks++;
        if (miss_cnt_o !== 8'd3) begin failures++; $display("FAIL missed_cnt got=%0d exp=3", miss_cnt_o); end
        checks++;
        if (miss_cnt_s !== 2'd3) begin failures++; $display("FAIL missed_cnt_narrow got=%0d exp=3", miss_cnt_s); end
    endtask

    task automatic test_saturate_clear();
        drive_clear();
        low_cycles_i = 16'd12; hold_cycles_i = 16'd4;
        drive_trig();
        for (int i = 1; i <= 30; i++) begin
            if (i == 7) begin
                checks++;
                if (miss_cnt_o !== 8'd5) begin failures++; $display("FAIL sat_wide got=%0d exp=5", miss_cnt_o); end
                checks++;
                if (miss_cnt_s !== 2'd3) begin failures++; $display("FAIL sat_narrow got=%0d exp=3", miss_cnt_s); end
            end
            if (i == 9) begin
                checks++;
                if (miss_cnt_o !== 8'd0 || miss_cnt_s !== 2'd0) begin
                    failures++;
                    $display("FAIL clear_vs_miss got wide=%0d narrow=%0d exp 0 0", miss_cnt_o, miss_cnt_s);
                end
            end
            trig_i     = (i >= 2 && i <= 6) || (i == 8);
            miss_clr_i = (i == 8);
            @(negedge clk_i);
        end
        trig_i = 1'b0; miss_clr_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0) begin failures++; $display("FAIL sat_end_idle got busy=%b exp=0", busy_o); end
    endtask

    task automatic test_back_to_back();
        int exp_miss;
        drive_clear();
        low_cycles_i = 16'd12; hold_cycles_i = 16'd2;
        trig_i = 1'b1;
        @(negedge clk_i);
        for (int i = 1; i <= 300; i++) begin
            if (i % 15 == 1) begin
                checks++;
                if (line_o !== 1'b0 || busy_o !== 1'b1) begin
                    failures++; $display("FAIL b2b_start idx=%0d got line=%b busy=%b exp 0 1", i, line_o, busy_o);
                end
            end
            if (i % 15 == 13) begin
                checks++;
                if (line_o !== 1'b1 || busy_o !== 1'b1) begin
                    failures++; $display("FAIL b2b_hold idx=%0d got line=%b busy=%b exp 1 1", i, line_o, busy_o);
                end
            end
            if (i % 15 == 0) begin
                exp_miss = 14 * (i / 15);
                if (exp_miss > 255) exp_miss = 255;
                checks++;
                if (done_o !== 1'b1 || busy_o !== 1'b0) begin
                    failures++; $display("FAIL b2b_done idx=%0d got done=%b busy=%b exp 1 0", i, done_o, busy_o);
                end
                checks++;
                if (miss_cnt_o !== 8'(exp_miss)) begin
                    failures++; $display("FAIL b2b_miss idx=%0d got=%0d exp=%0d", i, miss_cnt_o, exp_miss);
                end
            end
            if (i == 300) trig_i = 1'b0;
            @(negedge clk_i);
        end
        checks++;
        if (busy_o !== 1'b0 || line_o !== 1'b1 || miss_cnt_s !== 2'd3) begin
            failures++;
            $display("FAIL b2b_end got busy=%b line=%b narrow=%0d exp 0 1 3", busy_o, line_o, miss_cnt_s);
        end
    endtask

    task automatic test_reset_mid();
        int fl, ll, bl, da, dc;
        low_cycles_i = 16'd12; hold_cycles_i = 16'd4;
        drive_trig();
        for (int i = 1; i < 6; i++) @(negedge clk_i);
        rstn_i = 1'b0;
        #1;
        checks++;
        if (line_o !== 1'b1 || busy_o !== 1'b0 || state_o !== 2'd0) begin
            failures++; $display("FAIL reset_mid_async got line=%b busy=%b st=%0d exp 1 0 0", line_o, busy_o, state_o);
        end
        dc = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            if (done_o === 1'b1) dc++;
        end
        rstn_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (done_o === 1'b1) dc++;
        end
        checks++;
        if (dc !== 0) begin failures++; $display("FAIL reset_mid_no_done got=%0d exp=0", dc); end
        drive_trig();
        measure(40, fl, ll, bl, da, dc);
        checks++;
        if (fl !== 1 || ll !== 12) begin
            failures++; $display("FAIL reset_mid_fresh got first=%0d low=%0d exp 1 12", fl, ll);
        end
        checks++;
        if (da !== 17 || dc !== 1) begin
            failures++; $display("FAIL reset_mid_fresh_done got at=%0d n=%0d exp at=17 n=1", da, dc);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clamp();
        test_missed();
        test_saturate_clear();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
